// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO for the UART TX/RX paths, with level, thresholds and sticky errors.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses registered reads.
module uart_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AE_LVL  = (AW+1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              rd_acc;
    logic              wr_acc;

    assign full         = (level == LVL_MAX);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_acc && !rd_acc) begin
                level <= level + (AW+1)'(1);
            end else if (rd_acc && !wr_acc) begin
                level <= level - (AW+1)'(1);
            end
            // A new error event in the same cycle as clr_err keeps the flag set.
            if (wr_en && full && !rd_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef UART_FIFO_FWFT_EN
    assign rd_data  = rst ? '0 : mem[rd_ptr];
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_param.sv
// Self-checking bench for uart_fifo_param: random and directed traffic against a queue-based model.
// Follows the read mode selected by UART_FIFO_FWFT_EN.
module tb_uart_fifo_param;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 12;
    localparam int AEMPTY_TH = 2;
    localparam int AW        = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       level;
    logic              overflow;
    logic              underflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the FIFO contents as a plain queue plus sticky flags.
    logic [DATA_W-1:0] q[$];
    logic              exp_ovf = 1'b0;
    logic              exp_unf = 1'b0;
    logic              exp_valid = 1'b0;
    logic [DATA_W-1:0] exp_data = '0;

    uart_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
    endtask

    // Drives one clock of inputs, then advances the model by the FIFO rules.
    task automatic drive_cycle(input logic wr, input logic [DATA_W-1:0] d, input logic rd, input logic clr);
        int   n;
        logic rd_ok;
        logic wr_ok;
        n = q.size();
        wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
        @(posedge clk);
        #1;
        rd_ok = rd && (n > 0);
        wr_ok = wr && ((n < DEPTH) || rd_ok);
        if (wr && (n == DEPTH) && !rd_ok) exp_ovf = 1'b1; else if (clr) exp_ovf = 1'b0;
        if (rd && (n == 0)) exp_unf = 1'b1; else if (clr) exp_unf = 1'b0;
        exp_valid = rd_ok;
        if (rd_ok) exp_data = q.pop_front();
        if (wr_ok) q.push_back(d);
`ifdef UART_FIFO_FWFT_EN
        exp_valid = (q.size() > 0);
        if (q.size() > 0) exp_data = q[0];
`endif
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (level !== '0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        vectors++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got empty=%b ae=%b expected 1 1", empty, almost_empty); end
        vectors++; if (full !== 1'b0 || almost_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got full=%b af=%b expected 0 0", full, almost_full); end
        vectors++; if (rd_valid !== 1'b0 || rd_data !== '0) begin miscompares++; $display("[TB] FAIL reset_rd: got valid=%b data=%h expected 0 00", rd_valid, rd_data); end
        vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, DATA_W'(i + 1), 1'b0, 1'b0);
            vectors++; if (level !== (AW+1)'(i + 1)) begin miscompares++; $display("[TB] FAIL fill_level: got %0d expected %0d", level, i + 1); end
            vectors++; if (almost_full !== (i + 1 >= AFULL_TH)) begin miscompares++; $display("[TB] FAIL fill_afull: got %b at level %0d", almost_full, i + 1); end
            vectors++; if (almost_empty !== (i + 1 <= AEMPTY_TH)) begin miscompares++; $display("[TB] FAIL fill_aempty: got %b at level %0d", almost_empty, i + 1); end
        end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
        drive_cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
        vectors++; if (level !== (AW+1)'(DEPTH)) begin miscompares++; $display("[TB] FAIL ovf_level: got %0d expected %0d", level, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
`ifdef UART_FIFO_FWFT_EN
            vectors++; if (rd_valid !== 1'b1 || rd_data !== DATA_W'(i + 1)) begin miscompares++; $display("[TB] FAIL drain_head: got valid=%b data=%h expected 1 %h", rd_valid, rd_data, DATA_W'(i + 1)); end
`endif
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef UART_FIFO_FWFT_EN
            vectors++; if (rd_valid !== 1'b1 || rd_data !== DATA_W'(i + 1)) begin miscompares++; $display("[TB] FAIL drain_data: got valid=%b data=%h expected 1 %h", rd_valid, rd_data, DATA_W'(i + 1)); end
`endif
        end
        vectors++; if (empty !== 1'b1 || level !== '0) begin miscompares++; $display("[TB] FAIL drain_empty: got empty=%b level=%0d expected 1 0", empty, level); end
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_underflow();
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        vectors++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || level !== '0) begin miscompares++; $display("[TB] FAIL unf_set: got unf=%b valid=%b level=%0d expected 1 0 0", underflow, rd_valid, level); end
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL unf_clear: got %b expected 0", underflow); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("[TB] FAIL unf_set_wins: got %b expected 1", underflow); end
        // A write alongside a read on empty must not bypass: the read is still rejected.
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b1);
        vectors++; if (underflow !== 1'b1 || level !== (AW+1)'(1)) begin miscompares++; $display("[TB] FAIL no_bypass: got unf=%b level=%0d expected 1 1", underflow, level); end
        vectors++; if (rd_valid !== exp_valid) begin miscompares++; $display("[TB] FAIL no_bypass_valid: got %b expected %b", rd_valid, exp_valid); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        vectors++; if (rd_data !== 8'h77 && !empty) begin miscompares++; $display("[TB] FAIL no_bypass_data: got %h expected 77", rd_data); end
        vectors++; if (underflow !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("[TB] FAIL no_bypass_drain: got unf=%b empty=%b expected 0 1", underflow, empty); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h55, 1'b1, 1'b0);
        vectors++; if (level !== (AW+1)'(DEPTH) || overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL full_rw: got level=%0d ovf=%b expected %0d 0", level, overflow, DEPTH); end
        vectors++; if (rd_valid !== exp_valid || rd_data !== exp_data) begin miscompares++; $display("[TB] FAIL full_rw_data: got %b/%h expected %b/%h", rd_valid, rd_data, exp_valid, exp_data); end
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef UART_FIFO_FWFT_EN
            vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin miscompares++; $display("[TB] FAIL full_rw_drain: got %b/%h expected 1/%h", rd_valid, rd_data, exp_data); end
`endif
        end
        vectors++; if (exp_data !== 8'h55 || empty !== 1'b1) begin miscompares++; $display("[TB] FAIL full_rw_last: got last=%h empty=%b expected 55 1", exp_data, empty); end
    endtask

    task automatic test_wrap();
        int writes = 0;
        logic wr, rd;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
            writes++;
        end
        for (int cyc = 0; cyc < 400 && writes < 40; cyc++) begin
            wr = (q.size() <= 3) ? 1'b1 : (q.size() >= 5) ? 1'b0 : 1'($urandom_range(0, 1));
            rd = (q.size() >= 5) ? 1'b1 : (q.size() <= 3) ? 1'b0 : 1'($urandom_range(0, 1));
            if (wr) writes++;
            drive_cycle(wr, DATA_W'($urandom), rd, 1'b0);
            vectors++; if (level !== (AW+1)'(q.size())) begin miscompares++; $display("[TB] FAIL wrap_level: got %0d expected %0d", level, q.size()); end
            vectors++; if (rd_valid !== exp_valid || (exp_valid && rd_data !== exp_data)) begin miscompares++; $display("[TB] FAIL wrap_data: got %b/%h expected %b/%h", rd_valid, rd_data, exp_valid, exp_data); end
        end
        vectors++; if (writes < 40) begin miscompares++; $display("[TB] FAIL wrap_budget: got %0d writes expected 40", writes); end
        while (q.size() > 0) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
            vectors++; if (rd_valid !== exp_valid || (exp_valid && rd_data !== exp_data)) begin miscompares++; $display("[TB] FAIL wrap_drain: got %b/%h expected %b/%h", rd_valid, rd_data, exp_valid, exp_data); end
        end
    endtask

    task automatic test_random();
        logic wr, rd, clr;
        for (int cyc = 0; cyc < 400; cyc++) begin
            wr  = 1'($urandom_range(0, 99) < 55);
            rd  = 1'($urandom_range(0, 99) < 45);
            clr = 1'($urandom_range(0, 7) == 0);
            drive_cycle(wr, DATA_W'($urandom), rd, clr);
            vectors++; if (level !== (AW+1)'(q.size())) begin miscompares++; $display("[TB] FAIL rnd_level: got %0d expected %0d", level, q.size()); end
            vectors++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin miscompares++; $display("[TB] FAIL rnd_fe: got full=%b empty=%b at size %0d", full, empty, q.size()); end
            vectors++; if (almost_full !== (q.size() >= AFULL_TH) || almost_empty !== (q.size() <= AEMPTY_TH)) begin miscompares++; $display("[TB] FAIL rnd_thresh: got af=%b ae=%b at size %0d", almost_full, almost_empty, q.size()); end
            vectors++; if (overflow !== exp_ovf || underflow !== exp_unf) begin miscompares++; $display("[TB] FAIL rnd_err: got ovf=%b unf=%b expected %b %b", overflow, underflow, exp_ovf, exp_unf); end
            vectors++; if (rd_valid !== exp_valid || (exp_valid && rd_data !== exp_data)) begin miscompares++; $display("[TB] FAIL rnd_rd: got %b/%h expected %b/%h", rd_valid, rd_data, exp_valid, exp_data); end
        end
    endtask

    task automatic test_async_reset();
        while (q.size() > 0) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        vectors++; if (level !== (AW+1)'(7)) begin miscompares++; $display("[TB] FAIL arst_pre: got %0d expected 7", level); end
        // Assert reset between clock edges; outputs must react without waiting for clk.
        #3 rst = 1'b1;
        #1;
        vectors++; if (level !== '0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_now: got level=%0d empty=%b ae=%b full=%b", level, empty, almost_empty, full); end
        vectors++; if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_flags: got valid=%b ovf=%b unf=%b expected 0 0 0", rd_valid, overflow, underflow); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
`ifdef UART_FIFO_FWFT_EN
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin miscompares++; $display("[TB] FAIL arst_head: got %b/%h expected 1/3c", rd_valid, rd_data); end
`endif
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef UART_FIFO_FWFT_EN
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin miscompares++; $display("[TB] FAIL arst_read: got %b/%h expected 1/3c", rd_valid, rd_data); end
`endif
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_empty: got %b expected 1", empty); end
    endtask

`ifdef UART_FIFO_FWFT_EN
    task automatic test_fwft();
        drive_cycle(1'b1, 8'h9E, 1'b0, 1'b0);
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h9E) begin miscompares++; $display("[TB] FAIL fwft_head: got %b/%h expected 1/9e", rd_valid, rd_data); end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        vectors++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fwft_pop: got empty=%b valid=%b expected 1 0", empty, rd_valid); end
    endtask
`endif

    initial begin
        $display("[TB] starting uart_fifo_param bench");
        test_reset();
        test_fill_overflow();
        test_underflow();
        test_full_rw();
        test_wrap();
        test_random();
        test_async_reset();
`ifdef UART_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
